// File: rtl/decoupler_if.sv
// Wide-word in / narrow-element out link bundle for the decoupler.
// Both sides are FIFO-style: a beat moves on a rising edge when the request is high and the flag is low.
interface decoupler_if #(
  parameter int P_WIDTH = 32
);
  logic [2*P_WIDTH-1:0] i_data;
  logic                 i_enq;
  logic                 o_full;
  logic [P_WIDTH-1:0]   o_data;
  logic                 i_deq;
  logic                 o_empty;

  modport slave (
    input  i_data,
    input  i_enq,
    input  i_deq,
    output o_full,
    output o_data,
    output o_empty
  );

  modport master (
    output i_data,
    output i_enq,
    output i_deq,
    input  o_full,
    input  o_data,
    input  o_empty
  );
endinterface

// File: rtl/decoupler.sv
// Splits {hi,lo} words into a lo-first element stream; a word with lo==0 is a bare
// terminator and its hi half is dropped.

module decoupler_fifo #(
  parameter int W         = 32,
  parameter int DEPTH_LOG = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] wr_data,
  input  logic         push,
  output logic         full,
  output logic [W-1:0] rd_data,
  input  logic         pop,
  output logic         empty
);
  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0]   FULL_COUNT = (DEPTH_LOG+1)'(DEPTH);
  localparam logic [DEPTH_LOG:0]   CNT_ONE    = (DEPTH_LOG+1)'(1);
  localparam logic [DEPTH_LOG-1:0] PTR_ONE    = DEPTH_LOG'(1);

  logic [W-1:0]         mem_q [DEPTH];
  logic [DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG:0]   count_q, count_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 do_push;
  logic                 do_pop;

  // A push while full is dropped even if a pop frees a slot on the same edge.
  always_comb begin
    do_push  = push && !full_q;
    do_pop   = pop && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_ONE;
    end else if (do_pop && !do_push) begin
      count_d = count_q - CNT_ONE;
    end
    full_d  = (count_d == FULL_COUNT);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign full    = full_q;
  assign empty   = empty_q;
  assign rd_data = empty_q ? '0 : mem_q[rd_ptr_q];
endmodule

module decoupler #(
  parameter int P_WIDTH     = 32,
  parameter int P_DEPTH_LOG = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  decoupler_if.slave   bus,
  output logic         o_split_hi
);
  typedef enum logic {
    ST_LO = 1'b0,
    ST_HI = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [2*P_WIDTH-1:0]   in_head;
  logic                   in_empty;
  logic                   in_pop;
  logic [P_WIDTH-1:0]     out_data;
  logic                   out_push;
  logic                   out_full;

  decoupler_fifo #(
    .W         (2*P_WIDTH),
    .DEPTH_LOG (P_DEPTH_LOG)
  ) u_in_fifo (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .wr_data (bus.i_data),
    .push    (bus.i_enq),
    .full    (bus.o_full),
    .rd_data (in_head),
    .pop     (in_pop),
    .empty   (in_empty)
  );

  // The split only advances when it can both read a word and write an element,
  // so a stalled split resumes on the same half with nothing lost or repeated.
  always_comb begin
    state_d  = state_q;
    in_pop   = 1'b0;
    out_push = 1'b0;
    out_data = in_head[P_WIDTH-1:0];
    if (!in_empty && !out_full) begin
      out_push = 1'b1;
      if (state_q == ST_LO) begin
        if (in_head[P_WIDTH-1:0] == '0) begin
          in_pop = 1'b1;
        end else begin
          state_d = ST_HI;
        end
      end else begin
        out_data = in_head[2*P_WIDTH-1:P_WIDTH];
        in_pop   = 1'b1;
        state_d  = ST_LO;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_LO;
    end else begin
      state_q <= state_d;
    end
  end

  decoupler_fifo #(
    .W         (P_WIDTH),
    .DEPTH_LOG (P_DEPTH_LOG)
  ) u_out_fifo (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .wr_data (out_data),
    .push    (out_push),
    .full    (out_full),
    .rd_data (bus.o_data),
    .pop     (bus.i_deq),
    .empty   (bus.o_empty)
  );

  assign o_split_hi = (state_q == ST_HI);
endmodule
